// File: rtl/opb_status_pkg.sv
// Shared definitions for the OPB status bank.
// Holds the per-channel mode encodings, the CTRL word location, the FREEZE
// bit position, the counter ceiling and a byte-enable to bit-mask helper.
package opb_status_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE    = 2'b00,
        MODE_STICKY  = 2'b01,
        MODE_COUNTER = 2'b10,
        MODE_RSVD    = 2'b11   // behaves as live
    } ch_mode_e;

    localparam logic [4:0]  CTRL_WORD_IDX = 5'd31;
    localparam int          FREEZE_BIT    = 0;
    localparam logic [31:0] CNT_MAX       = 32'hFFFF_FFFF;

    // be[3] covers data bits 31:24 (it carries OPB_BE[0], the big-endian
    // first lane), be[0] covers data bits 7:0.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/opb_status_chan.sv
// One status channel: live capture, sticky accumulator or rising-edge
// counter on bit 0, selected at elaboration by C_MODE, plus a snapshot
// register used while the bank is frozen.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_data           raw channel input (synchronous to i_clk)
//   i_wr             a bus write to this channel's word is being accepted
//   i_wmask          sticky bits to clear (write data AND byte enables)
//   i_freeze         bank FREEZE bit; selects the snapshot for reads
//   i_freeze_rise    FREEZE going 0->1 on this edge; capture the snapshot
//   o_rdata          value presented on a read of this channel
module opb_status_chan
    import opb_status_pkg::*;
#(
    parameter logic [1:0] C_MODE = MODE_LIVE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data,
    input  logic        i_wr,
    input  logic [31:0] i_wmask,
    input  logic        i_freeze,
    input  logic        i_freeze_rise,
    output logic [31:0] o_rdata
);

    logic [31:0] r_live;
    logic [31:0] r_sticky;
    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_prev_b0;
    logic        w_rise;
    logic [31:0] w_val;

    assign w_rise = i_data[0] & ~r_prev_b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live    <= '0;
            r_sticky  <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_prev_b0 <= 1'b0;
        end else begin
            r_live    <= i_data;
            r_prev_b0 <= i_data[0];
            // Clear is applied first and the new input ORed in after, so a
            // bit that is set and cleared on the same edge stays set.
            r_sticky  <= (r_sticky & ~(i_wr ? i_wmask : 32'd0)) | i_data;
            // A write always wins over a coincident edge.
            if (i_wr) begin
                r_cnt <= '0;
            end else if (w_rise && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (i_freeze_rise) begin
                r_snap <= w_val;
            end
        end
    end

    always_comb begin
        w_val = r_live;
        case (C_MODE)
            MODE_STICKY:  w_val = r_sticky;
            MODE_COUNTER: w_val = r_cnt;
            default:      w_val = r_live;
        endcase
    end

    assign o_rdata = i_freeze ? r_snap : w_val;

endmodule

// File: rtl/opb_status_bank.sv
// OPB slave exposing C_NUM_CH 32-bit status channels in a 32-word window.
// Word ch (< C_NUM_CH) reads the channel value; word 31 is CTRL with FREEZE
// in bit 0; the remaining words read 0 and ignore writes. Every hit is acked
// exactly once, one cycle after the first hit cycle.
// Ports:
//   OPB_Clk, OPB_Rst_n          clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW/select  OPB slave request (big-endian bit order)
//   OPB_seqAddr                 accepted but unused
//   user_data_in                channel ch on bits [32*ch+31:32*ch]
//   Sl_DBus, Sl_xferAck         read data (zero outside the ack) and ack
//   Sl_errAck, Sl_retry, Sl_toutSup  tied low
module opb_status_bank
    import opb_status_pkg::*;
#(
    parameter logic [31:0]           C_BASEADDR   = 32'h0108_3700,
    parameter logic [31:0]           C_HIGHADDR   = 32'h0108_377F,
    parameter int                    C_OPB_AWIDTH = 32,
    parameter int                    C_OPB_DWIDTH = 32,
    parameter int                    C_NUM_CH     = 4,
    parameter logic [2*C_NUM_CH-1:0] C_CH_MODE    = '0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    input  logic [C_NUM_CH*32-1:0]    user_data_in,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup
);

    logic        r_ack;
    logic [31:0] r_dbus;
    logic        r_freeze;

    // Vector assignment keeps the numeric value: bus bit 0 lands on bit 31.
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [4:0]  w_idx;
    logic        w_hit;
    logic        w_start;
    logic        w_wr;
    logic [31:0] w_clr_mask;
    logic        w_ctrl_wr;
    logic        w_freeze_nxt;
    logic        w_freeze_rise;
    logic [31:0] w_rdata;
    logic [31:0] w_ch_rdata [C_NUM_CH];
    logic        w_unused_seq;

    assign w_addr       = OPB_ABus;
    assign w_wdata      = OPB_DBus;
    assign w_be         = OPB_BE;
    assign w_idx        = OPB_ABus[25:29];
    assign w_unused_seq = OPB_seqAddr;

    assign w_hit      = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    // A hit while the ack is already out is the tail of the same transfer.
    assign w_start    = w_hit & ~r_ack;
    assign w_wr       = w_start & ~OPB_RNW;
    assign w_clr_mask = w_wdata & be_to_mask(w_be);

    // FREEZE sits in byte lane 7:0, so it follows that lane's enable.
    assign w_ctrl_wr     = w_wr && (w_idx == CTRL_WORD_IDX) && w_be[0];
    assign w_freeze_nxt  = w_ctrl_wr ? w_wdata[FREEZE_BIT] : r_freeze;
    assign w_freeze_rise = w_freeze_nxt & ~r_freeze;

    for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_chan
        opb_status_chan #(
            .C_MODE(C_CH_MODE[2*gi +: 2])
        ) u_chan (
            .i_clk        (OPB_Clk),
            .i_rst_n      (OPB_Rst_n),
            .i_data       (user_data_in[32*gi +: 32]),
            .i_wr         (w_wr && (w_idx == 5'(gi))),
            .i_wmask      (w_clr_mask),
            .i_freeze     (r_freeze),
            .i_freeze_rise(w_freeze_rise),
            .o_rdata      (w_ch_rdata[gi])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_idx == CTRL_WORD_IDX) begin
            w_rdata[FREEZE_BIT] = r_freeze;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (w_idx == 5'(i)) begin
                    w_rdata = w_ch_rdata[i];
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_ack    <= 1'b0;
            r_dbus   <= '0;
            r_freeze <= 1'b0;
        end else begin
            r_ack    <= w_start;
            r_dbus   <= (w_start && OPB_RNW) ? w_rdata : 32'd0;
            r_freeze <= w_freeze_nxt;
        end
    end

    assign Sl_xferAck = r_ack;
    assign Sl_DBus    = r_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_status_bank.sv
// Directed bench for opb_status_bank: ch0 live, ch1 sticky, ch2 counter,
// ch3 live. Bus transfers are driven on the falling edge and the response
// is sampled 1 ns after the rising edge.
module tb_opb_status_bank;

    localparam logic [31:0] BASE = 32'h0108_3700;
    localparam logic [31:0] HIGH = 32'h0108_377F;
    localparam logic [31:0] CTRL = BASE + 32'h7C;
    localparam int          NCH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [0:31]       abus;
    logic [0:3]        be;
    logic [0:31]       dbus;
    logic              rnw;
    logic              sel;
    logic              seq;
    logic [NCH*32-1:0] udata;
    logic [0:31]       sl_dbus;
    logic              sl_ack;
    logic              sl_err;
    logic              sl_retry;
    logic              sl_tout;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    opb_status_bank #(
        .C_NUM_CH (NCH),
        .C_CH_MODE(8'b00_10_01_00)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .user_data_in(udata),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_ack),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tout)
    );

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        sel  = 1'b0;
        rnw  = 1'b0;
        abus = '0;
        dbus = '0;
        be   = '0;
    endtask

    task automatic bus_start(input logic [31:0] addr, input logic is_rd,
                             input logic [31:0] wd, input logic [3:0] bev);
        @(negedge clk);
        abus = addr;
        rnw  = is_rd;
        dbus = wd;
        be   = bev;
        sel  = 1'b1;
    endtask

    task automatic bus_finish(input string tag);
        logic [31:0] exp;
        @(posedge clk);
        #1;
        check_vec({tag, ".ack"}, 32'(sl_ack), 32'd1);
        if (rnw) begin
            exp = exp_q.pop_front();
            check_vec({tag, ".data"}, sl_dbus, exp);
        end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1;
        check_vec({tag, ".ack_end"}, 32'(sl_ack), 32'd0);
        check_vec({tag, ".dbus_end"}, sl_dbus, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        bus_start(addr, 1'b1, 32'd0, 4'hF);
        bus_finish(tag);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] bev, input string tag);
        bus_start(addr, 1'b0, wd, bev);
        bus_finish(tag);
    endtask

    // Write with one input bit high only on the accepting edge.
    task automatic write_with_pulse(input logic [31:0] addr, input logic [31:0] wd,
                                    input int pos, input string tag);
        @(negedge clk);
        abus       = addr;
        rnw        = 1'b0;
        dbus       = wd;
        be         = 4'hF;
        sel        = 1'b1;
        udata[pos] = 1'b1;
        @(posedge clk);
        #1;
        check_vec({tag, ".ack"}, 32'(sl_ack), 32'd1);
        @(negedge clk);
        bus_idle();
        udata[pos] = 1'b0;
    endtask

    task automatic pulse_bit(input int pos);
        @(negedge clk);
        udata[pos] = 1'b1;
        @(negedge clk);
        udata[pos] = 1'b0;
    endtask

    task automatic expect_no_ack(input logic [31:0] addr, input logic s, input string tag);
        @(negedge clk);
        abus = addr;
        rnw  = 1'b1;
        be   = 4'hF;
        sel  = s;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_vec(tag, 32'(sl_ack), 32'd0);
        end
        @(negedge clk);
        bus_idle();
    endtask

    // ---------------- stimulus ----------------
    logic [4:0]  hold_ack;
    logic [31:0] oor_addr [3];

    initial begin
        bus_idle();
        seq   = 1'b0;
        udata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst.ack", 32'(sl_ack), 32'd0);
        check_vec("rst.dbus", sl_dbus, 32'd0);
        check_vec("rst.tied", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_read(BASE + 32'h4, 32'd0, "rst_sticky");
        bus_read(BASE + 32'h8, 32'd0, "rst_cnt");
        bus_read(CTRL, 32'd0, "rst_ctrl");

        // live channels
        udata[31:0]   = 32'hDEAD_BEEF;
        udata[127:96] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        bus_read(BASE, 32'hDEAD_BEEF, "live0");
        bus_read(BASE + 32'hC, 32'h1234_5678, "live3");
        bus_write(BASE, 32'hFFFF_FFFF, 4'hF, "live0_wr");
        bus_read(BASE, 32'hDEAD_BEEF, "live0_wr_ignored");

        // sticky channel
        @(negedge clk);
        udata[63:32] = 32'h5;
        @(negedge clk);
        udata[63:32] = 32'h0;
        bus_read(BASE + 32'h4, 32'h5, "sticky_set");
        bus_write(BASE + 32'h4, 32'h1, 4'hF, "sticky_clr1");
        bus_read(BASE + 32'h4, 32'h4, "sticky_after_clr1");
        bus_write(BASE + 32'h4, 32'h4, 4'b1110, "sticky_clr_be");
        bus_read(BASE + 32'h4, 32'h4, "sticky_be_masked");
        write_with_pulse(BASE + 32'h4, 32'h4, 34, "sticky_setwins");
        bus_read(BASE + 32'h4, 32'h4, "sticky_setwins_rd");
        bus_write(BASE + 32'h4, 32'h4, 4'hF, "sticky_clr4");
        bus_read(BASE + 32'h4, 32'h0, "sticky_empty");

        // counter channel
        repeat (3) pulse_bit(64);
        bus_read(BASE + 32'h8, 32'd3, "cnt_3edges");
        write_with_pulse(BASE + 32'h8, 32'h0, 64, "cnt_clrwins");
        bus_read(BASE + 32'h8, 32'd0, "cnt_clrwins_rd");
        pulse_bit(64);
        bus_read(BASE + 32'h8, 32'd1, "cnt_resume");
        @(negedge clk);
        dut.g_chan[2].u_chan.r_cnt = 32'hFFFF_FFFD;
        repeat (2) pulse_bit(64);
        bus_read(BASE + 32'h8, 32'hFFFF_FFFF, "cnt_reach_max");
        pulse_bit(64);
        bus_read(BASE + 32'h8, 32'hFFFF_FFFF, "cnt_saturate");
        bus_write(BASE + 32'h8, 32'h0, 4'h0, "cnt_clr_be0");
        bus_read(BASE + 32'h8, 32'd0, "cnt_cleared");

        // freeze
        pulse_bit(35);
        pulse_bit(64);
        bus_write(CTRL, 32'h1, 4'hF, "frz_set");
        bus_read(CTRL, 32'h1, "frz_ctrl_rd");
        udata[31:0] = 32'h0BAD_F00D;
        pulse_bit(64);
        pulse_bit(64);
        pulse_bit(32);
        repeat (2) @(negedge clk);
        bus_read(BASE, 32'hDEAD_BEEF, "frz_ch0");
        bus_read(BASE + 32'h4, 32'h8, "frz_ch1");
        bus_read(BASE + 32'h8, 32'd1, "frz_ch2");
        bus_read(BASE + 32'hC, 32'h1234_5678, "frz_ch3");
        bus_write(CTRL, 32'h0, 4'hF, "frz_clr");
        bus_read(BASE, 32'h0BAD_F00D, "unfrz_ch0");
        bus_read(BASE + 32'h4, 32'h9, "unfrz_ch1");
        bus_read(BASE + 32'h8, 32'd3, "unfrz_ch2");

        // select held four cycles: acks in cycles 2 and 4 only
        hold_ack = 5'b00101;
        @(negedge clk);
        abus = BASE + 32'hC;
        rnw  = 1'b1;
        be   = 4'hF;
        seq  = 1'b1;
        sel  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("hold.ack_c%0d", i + 2), 32'(sl_ack), 32'(hold_ack[i]));
            check_vec($sformatf("hold.dbus_c%0d", i + 2), sl_dbus,
                      hold_ack[i] ? 32'h1234_5678 : 32'h0);
            if (i == 3) begin
                @(negedge clk);
                bus_idle();
                seq = 1'b0;
            end
        end

        // address decode boundaries
        oor_addr[0] = HIGH + 32'h4;
        oor_addr[1] = BASE - 32'h4;
        oor_addr[2] = BASE + 32'h80;
        for (int i = 0; i < 3; i++) begin
            expect_no_ack(oor_addr[i], 1'b1, $sformatf("oor%0d.ack", i));
        end
        expect_no_ack(BASE, 1'b0, "nosel.ack");
        bus_write(BASE + 32'h28, 32'hFFFF_FFFF, 4'hF, "unmapped10_wr");
        bus_read(BASE + 32'h28, 32'h0, "unmapped10_rd");
        bus_read(BASE + 32'h78, 32'h0, "unmapped30_rd");

        // reset clears an ack that is already out
        bus_write(CTRL, 32'h1, 4'hF, "pre_rst_frz");
        @(negedge clk);
        abus = BASE + 32'hC;
        rnw  = 1'b1;
        be   = 4'hF;
        sel  = 1'b1;
        @(posedge clk);
        #1;
        check_vec("rst_live.ack_before", 32'(sl_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_vec("rst_live.ack", 32'(sl_ack), 32'd0);
        check_vec("rst_live.dbus", sl_dbus, 32'd0);
        @(negedge clk);
        bus_idle();
        rst_n = 1'b1;

        // reset before the acking edge aborts; the next hit is acked
        @(negedge clk);
        abus = BASE + 32'h4;
        rnw  = 1'b1;
        be   = 4'hF;
        sel  = 1'b1;
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("rst_abort.ack%0d", k), 32'(sl_ack), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_vec("rst_after.ack", 32'(sl_ack), 32'd1);
        check_vec("rst_after.sticky", sl_dbus, 32'd0);
        @(negedge clk);
        bus_idle();
        bus_read(BASE + 32'h8, 32'd0, "rst_after_cnt");
        bus_read(CTRL, 32'd0, "rst_after_ctrl");
        bus_read(BASE, 32'h0BAD_F00D, "rst_after_live0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
